// File: rtl/inst_stream_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_stream_feeder_if
// Description : Bundles the load, control, redirect and playback signals of
//               the instruction stream feeder. The master modport is the
//               controlling side (bench / bring-up host); the slave modport
//               is the feeder itself.
// Ports       : load    - wr_en, wr_data, clear
//               control - mode, start, step, stall, abort
//               branch  - redirect_valid, redirect_off
//               output  - inst, inst_valid, pc, count, full, empty, busy,
//                         done, loop_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_stream_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int OFF_W  = 8
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              clear;
  logic [1:0]        mode;
  logic              start;
  logic              step;
  logic              stall;
  logic              abort;
  logic              redirect_valid;
  logic [OFF_W-1:0]  redirect_off;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              busy;
  logic              done;
  logic [15:0]       loop_cnt;

  modport master (
    output wr_en, wr_data, clear, mode, start, step, stall, abort,
           redirect_valid, redirect_off,
    input  inst, inst_valid, pc, count, full, empty, busy, done, loop_cnt
  );

  modport slave (
    input  wr_en, wr_data, clear, mode, start, step, stall, abort,
           redirect_valid, redirect_off,
    output inst, inst_valid, pc, count, full, empty, busy, done, loop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/inst_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : inst_stream_feeder
// Description : Preloaded instruction buffer that replays up to DEPTH words
//               onto the CPU instruction input in run, single-step or loop
//               mode, honouring CPU stall and PC-relative redirects.
// Ports       : clk - rising-edge clock
//               rst - synchronous reset, active low
//               bus - inst_stream_feeder_if.slave (load, control, redirect
//                     inputs; inst/inst_valid/pc and status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_stream_feeder #(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 32,
  parameter int                ADDR_W   = 5,
  parameter int                OFF_W    = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0800
) (
  input wire logic            clk,
  input wire logic            rst,
  inst_stream_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]      c_MODE_STEP = 2'b01;
  localparam logic [1:0]      c_MODE_LOOP = 2'b10;
  localparam logic [ADDR_W:0] c_ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W+1)'(DEPTH);
  // Redirect target width: wide enough for any pc plus any signed offset,
  // so the sum never wraps and an out-of-range target is always detected.
  localparam int              c_T_W       = ((ADDR_W > OFF_W) ? ADDR_W : OFF_W) + 2;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state,    w_state_nxt;
  logic [DATA_W-1:0] r_inst,     w_inst_nxt;
  logic              r_valid,    w_valid_nxt;
  logic [ADDR_W-1:0] r_pc,       w_pc_nxt;
  logic [ADDR_W:0]   r_count,    w_count_nxt;
  logic [15:0]       r_loop_cnt, w_loop_nxt;
  logic [1:0]        r_mode,     w_mode_nxt;
  logic [ADDR_W-1:0] r_nidx,     w_nidx_nxt;   // next word to present in STEP

  logic              w_loadable;
  logic              w_full;
  logic              w_wr;
  logic [ADDR_W:0]   w_n;
  logic              w_n_end;
  logic [c_T_W-1:0]  w_t;
  logic              w_t_ok;
  logic              w_to_done;

  assign w_loadable = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_full     = (r_count == c_DEPTH);
  assign w_wr       = rst && w_loadable && bus.wr_en && !bus.clear && !w_full;

  // Sequential successor of the current word and the end-of-buffer test.
  assign w_n        = {1'b0, r_pc} + c_ONE;
  assign w_n_end    = (w_n == r_count);

  // Signed redirect target; negative values show up as a set top bit.
  assign w_t    = {{(c_T_W-ADDR_W){1'b0}}, r_pc}
                + {{(c_T_W-OFF_W){bus.redirect_off[OFF_W-1]}}, bus.redirect_off};
  assign w_t_ok = !w_t[c_T_W-1] && (w_t < {{(c_T_W-ADDR_W-1){1'b0}}, r_count});

  // Buffer RAM: write-only port, no reset (contents are don't-care).
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_count[ADDR_W-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_inst     <= NOP_WORD;
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_count    <= '0;
      r_loop_cnt <= '0;
      r_mode     <= '0;
      r_nidx     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inst     <= w_inst_nxt;
      r_valid    <= w_valid_nxt;
      r_pc       <= w_pc_nxt;
      r_count    <= w_count_nxt;
      r_loop_cnt <= w_loop_nxt;
      r_mode     <= w_mode_nxt;
      r_nidx     <= w_nidx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_inst_nxt  = r_inst;
    w_valid_nxt = r_valid;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_loop_nxt  = r_loop_cnt;
    w_mode_nxt  = r_mode;
    w_nidx_nxt  = r_nidx;
    w_to_done   = 1'b0;

    if (w_loadable) begin
      if (bus.clear) begin
        w_count_nxt = '0;
      end else if (w_wr) begin
        w_count_nxt = r_count + c_ONE;
      end
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_loop_nxt = '0;
          w_mode_nxt = bus.mode;
          w_pc_nxt   = '0;
          w_nidx_nxt = '0;
          if (r_count == '0) begin
            w_to_done = 1'b1;
          end else if (bus.mode == c_MODE_STEP) begin
            w_state_nxt = S_STEP;
            w_inst_nxt  = NOP_WORD;
            w_valid_nxt = 1'b0;
          end else begin
            w_state_nxt = S_RUN;
            w_inst_nxt  = r_mem[0];
            w_valid_nxt = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (bus.redirect_valid) begin
          if (w_t_ok) begin
            w_inst_nxt = r_mem[w_t[ADDR_W-1:0]];
            w_pc_nxt   = w_t[ADDR_W-1:0];
          end else begin
            w_to_done = 1'b1;
          end
        end else if (!bus.stall) begin
          if (!w_n_end) begin
            w_inst_nxt = r_mem[w_n[ADDR_W-1:0]];
            w_pc_nxt   = w_n[ADDR_W-1:0];
          end else if (r_mode == c_MODE_LOOP) begin
            // Wrap straight to word 0: no bubble between passes.
            w_inst_nxt = r_mem[0];
            w_pc_nxt   = '0;
            w_loop_nxt = r_loop_cnt + 16'd1;
          end else begin
            w_to_done = 1'b1;
          end
        end
      end

      S_STEP: begin
        if (r_valid) begin
          // A word is on the bus: it is consumed unless stalled.
          if (bus.redirect_valid) begin
            if (w_t_ok) begin
              w_inst_nxt = r_mem[w_t[ADDR_W-1:0]];
              w_pc_nxt   = w_t[ADDR_W-1:0];
            end else begin
              w_to_done = 1'b1;
            end
          end else if (!bus.stall) begin
            if (w_n_end) begin
              w_to_done = 1'b1;
            end else if (bus.step) begin
              w_inst_nxt = r_mem[w_n[ADDR_W-1:0]];
              w_pc_nxt   = w_n[ADDR_W-1:0];
            end else begin
              w_inst_nxt  = NOP_WORD;
              w_valid_nxt = 1'b0;
              w_nidx_nxt  = w_n[ADDR_W-1:0];
            end
          end
        end else if (bus.step && !bus.stall) begin
          w_inst_nxt  = r_mem[r_nidx];
          w_pc_nxt    = r_nidx;
          w_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_to_done) begin
      w_state_nxt = S_DONE;
      w_inst_nxt  = NOP_WORD;
      w_valid_nxt = 1'b0;
    end

    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_inst_nxt  = NOP_WORD;
      w_valid_nxt = 1'b0;
    end
  end

  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_valid;
  assign bus.pc         = r_pc;
  assign bus.count      = r_count;
  assign bus.full       = w_full;
  assign bus.empty      = (r_count == '0);
  assign bus.busy       = (r_state == S_RUN) || (r_state == S_STEP);
  assign bus.done       = (r_state == S_DONE);
  assign bus.loop_cnt   = r_loop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_stream_feeder
// Description : Self-checking bench for inst_stream_feeder. Stimulus tasks
//               update a word-level playback model and queue the expected
//               (inst, pc) of every valid word; a monitor pops and compares
//               whenever the feeder presents a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_stream_feeder;
  localparam int          DATA_W = 16;
  localparam int          DEPTH  = 32;
  localparam int          ADDR_W = 5;
  localparam int          OFF_W  = 8;
  localparam logic [15:0] NOP    = 16'h0800;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_stream_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus ();

  inst_stream_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OFF_W(OFF_W), .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [15:0] w;
    logic [4:0]  pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Word-level playback model
  logic [15:0] m_buf [DEPTH];
  int m_len, m_pos, m_next, m_lc;
  bit m_active, m_shown, m_loop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pos();
    exp_t e;
    e.w  = m_buf[m_pos];
    e.pc = 5'(m_pos);
    exp_q.push_back(e);
  endtask

  // Monitor: every valid word must be the next expected one; idle cycles
  // must show the NOP word.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.inst_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got inst=%h pc=%0d expected no valid word", bus.inst, bus.pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.inst !== e.w || bus.pc !== e.pc) begin
            failures++;
            $display("FAIL stream_word: got inst=%h pc=%0d expected inst=%h pc=%0d",
                     bus.inst, bus.pc, e.w, e.pc);
          end
        end
      end else begin
        checks++;
        if (bus.inst !== NOP) begin
          failures++;
          $display("FAIL idle_nop: got inst=%h expected %h", bus.inst, NOP);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.clear = 1'b0; bus.mode = 2'b00;
    bus.start = 1'b0; bus.step = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_off = '0;
  endtask

  task automatic load_word(input logic [15:0] w);
    bus.wr_en = 1'b1; bus.wr_data = w;
    tick();
    bus.wr_en = 1'b0;
    if (m_len < DEPTH) begin
      m_buf[m_len] = w;
      m_len++;
    end
  endtask

  task automatic clear_buf();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    m_len = 0;
  endtask

  task automatic start_play(input logic [1:0] mode);
    bus.start = 1'b1; bus.mode = mode;
    m_lc = 0; m_loop = (mode == 2'b10); m_shown = 1'b0; m_next = 0; m_pos = 0;
    m_active = (m_len > 0);
    if (m_active && mode != 2'b01) begin
      m_shown = 1'b1;
      push_pos();
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic abort_play();
    bus.abort = 1'b1;
    m_active = 1'b0; m_shown = 1'b0;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic model_redirect(input logic [7:0] off);
    int t;
    t = m_pos + int'($signed(off));
    if (t >= 0 && t < m_len) begin
      m_pos = t;
      push_pos();
    end else begin
      m_active = 1'b0; m_shown = 1'b0;
    end
  endtask

  // One edge of continuous playback (run / loop / reserved mode).
  task automatic run_cycle(input bit stall, input bit rv, input logic [7:0] off);
    bus.stall = stall; bus.redirect_valid = rv; bus.redirect_off = off;
    if (rv) model_redirect(off);
    else if (stall) push_pos();
    else if (m_pos + 1 < m_len) begin m_pos++; push_pos(); end
    else if (m_loop) begin m_pos = 0; m_lc++; push_pos(); end
    else m_active = 1'b0;
    tick();
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
  endtask

  // One edge of single-step playback.
  task automatic step_cycle(input bit step, input bit stall, input bit rv, input logic [7:0] off);
    bus.step = step; bus.stall = stall; bus.redirect_valid = rv; bus.redirect_off = off;
    if (m_shown) begin
      if (rv) model_redirect(off);
      else if (stall) push_pos();
      else if (m_pos + 1 >= m_len) begin m_active = 1'b0; m_shown = 1'b0; end
      else if (step) begin m_pos++; push_pos(); end
      else begin m_shown = 1'b0; m_next = m_pos + 1; end
    end else if (step && !stall) begin
      m_pos = m_next; m_shown = 1'b1; push_pos();
    end
    tick();
    bus.step = 1'b0; bus.stall = 1'b0; bus.redirect_valid = 1'b0;
  endtask

  task automatic random_round();
    int         len;
    int         budget;
    logic [1:0] mode;
    len = $urandom_range(1, DEPTH);
    clear_buf();
    for (int i = 0; i < len; i++) load_word(16'($urandom));
    chk("rnd_count", 32'(bus.count), 32'(m_len));
    mode = 2'($urandom_range(0, 3));
    start_play(mode);
    budget = 0;
    while (m_active && budget < 80) begin
      bit         st;
      bit         rv;
      bit         sp;
      logic [7:0] off;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 1) == 0);
      off = ($urandom_range(0, 9) == 0) ? 8'h7F : 8'(int'($urandom_range(0, 10)) - 5);
      if (mode == 2'b01) step_cycle(sp, st, rv, off);
      else               run_cycle(st, rv, off);
      budget++;
    end
    chk("rnd_loop_cnt", 32'(bus.loop_cnt), 32'(16'(m_lc)));
    if (m_active) begin
      abort_play();
      chk("rnd_abort_busy", 32'(bus.busy), 32'(0));
      chk("rnd_abort_count", 32'(bus.count), 32'(m_len));
    end else begin
      chk("rnd_done", 32'(bus.done), 32'(1));
    end
  endtask

  initial begin
    int guard;
    drive_idle();
    m_len = 0; m_active = 1'b0; m_shown = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    mon_en = 1'b1;

    // Reset state
    chk("rst_inst",     32'(bus.inst),       32'(NOP));
    chk("rst_valid",    32'(bus.inst_valid), 32'(0));
    chk("rst_pc",       32'(bus.pc),         32'(0));
    chk("rst_count",    32'(bus.count),      32'(0));
    chk("rst_empty",    32'(bus.empty),      32'(1));
    chk("rst_full",     32'(bus.full),       32'(0));
    chk("rst_busy",     32'(bus.busy),       32'(0));
    chk("rst_done",     32'(bus.done),       32'(0));
    chk("rst_loop_cnt", 32'(bus.loop_cnt),   32'(0));

    // Plain run of three words
    load_word(16'h6AFF); load_word(16'h6BC0); load_word(16'h3360);
    chk("load3_count", 32'(bus.count), 32'(3));
    chk("load3_empty", 32'(bus.empty), 32'(0));
    start_play(2'b00);
    chk("run_busy", 32'(bus.busy), 32'(1));
    repeat (3) run_cycle(1'b0, 1'b0, 8'h00);
    chk("run_done",  32'(bus.done),       32'(1));
    chk("run_valid", 32'(bus.inst_valid), 32'(0));
    chk("run_nop",   32'(bus.inst),       32'(NOP));

    // Overfill: last write dropped, exactly DEPTH words replay
    clear_buf();
    chk("clear_empty", 32'(bus.empty), 32'(1));
    for (int i = 0; i <= DEPTH; i++) load_word(16'($urandom));
    chk("full_flag",  32'(bus.full),  32'(1));
    chk("full_count", 32'(bus.count), 32'(DEPTH));
    start_play(2'b00);
    guard = 0;
    while (m_active && guard < DEPTH + 4) begin run_cycle(1'b0, 1'b0, 8'h00); guard++; end
    chk("full_words_played", 32'(guard), 32'(DEPTH));
    chk("full_done", 32'(bus.done), 32'(1));

    // Loop mode with backward and out-of-range redirects
    clear_buf();
    load_word(16'h4D01); load_word(16'h2DF7); load_word(16'h0800);
    start_play(2'b10);
    run_cycle(1'b0, 1'b0, 8'h00);
    run_cycle(1'b0, 1'b1, 8'hFF);
    chk("redir_back_pc",   32'(bus.pc),   32'(0));
    chk("redir_back_inst", 32'(bus.inst), 32'(16'h4D01));
    run_cycle(1'b0, 1'b0, 8'h00);
    run_cycle(1'b0, 1'b1, 8'h7F);
    chk("redir_far_done", 32'(bus.done), 32'(1));

    // Stall holds a word; redirect beats stall
    start_play(2'b00);
    run_cycle(1'b0, 1'b0, 8'h00);
    repeat (3) run_cycle(1'b1, 1'b0, 8'h00);
    chk("stall_hold_pc", 32'(bus.pc), 32'(1));
    run_cycle(1'b0, 1'b0, 8'h00);
    chk("stall_resume_pc", 32'(bus.pc), 32'(2));
    run_cycle(1'b0, 1'b0, 8'h00);
    start_play(2'b00);
    run_cycle(1'b0, 1'b0, 8'h00);
    run_cycle(1'b1, 1'b1, 8'hFF);
    chk("redir_over_stall_pc", 32'(bus.pc), 32'(0));
    guard = 0;
    while (m_active && guard < 8) begin run_cycle(1'b0, 1'b0, 8'h00); guard++; end

    // Single-step: spaced pulses, then step held high
    start_play(2'b01);
    chk("step_idle_valid", 32'(bus.inst_valid), 32'(0));
    for (int k = 0; k < 3; k++) begin
      step_cycle(1'b1, 1'b0, 1'b0, 8'h00);
      chk("step_word_valid", 32'(bus.inst_valid), 32'(1));
      repeat (4) step_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    end
    chk("step_done", 32'(bus.done), 32'(1));
    start_play(2'b01);
    guard = 0;
    while (m_active && guard < 10) begin step_cycle(1'b1, 1'b0, 1'b0, 8'h00); guard++; end
    chk("step_held_done", 32'(bus.done), 32'(1));

    // Loop counting, abort and mid-run reset
    clear_buf();
    load_word(16'h1111); load_word(16'h2222);
    start_play(2'b10);
    repeat (6) run_cycle(1'b0, 1'b0, 8'h00);
    chk("loop_cnt3", 32'(bus.loop_cnt), 32'(3));
    abort_play();
    chk("abort_count", 32'(bus.count), 32'(2));
    chk("abort_busy",  32'(bus.busy),  32'(0));
    chk("abort_done",  32'(bus.done),  32'(0));
    chk("abort_inst",  32'(bus.inst),  32'(NOP));
    start_play(2'b10);
    repeat (3) run_cycle(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    m_len = 0; m_active = 1'b0; m_shown = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_count",    32'(bus.count),      32'(0));
    chk("mrst_inst",     32'(bus.inst),       32'(NOP));
    chk("mrst_valid",    32'(bus.inst_valid), 32'(0));
    chk("mrst_busy",     32'(bus.busy),       32'(0));
    chk("mrst_loop_cnt", 32'(bus.loop_cnt),   32'(0));

    // Randomised rounds across all modes
    for (int r = 0; r < 12; r++) random_round();

    repeat (2) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
